// File: rtl/seg_scan_ctrl.sv
// =============================================================================
// seg_scan_ctrl : double-buffered, blanked-gap scan controller for a
//                 common-anode multiplexed seven-segment display.
// Optional feature macro: SEG_LEADING_ZERO_SUPPRESS_EN
// Revision      : 1.0
// =============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            digit,
  output logic                  dp_n,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST      = IW'(DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shd_val_q, shd_val_d, act_val_q, act_val_d;
  logic [DIGITS-1:0]     shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]     shd_mask_q, shd_mask_d, act_mask_q, act_mask_d;
  logic                  pending_q, pending_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [3:0]            digit_q, digit_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end, frame_end, commit, drive_d;
  logic [DIGITS-1:0]     suppress, dark;
  logic                  lz_run;

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == CNT_BLANK_END) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_end)               state_d = ST_BLANK;
      default:                              state_d = ST_BLANK;
    endcase
    drive_d = (state_d == ST_DRIVE);

    // Commit uses the pre-load shadow; a coincident load stays pending.
    commit     = frame_end && pending_q;
    act_val_d  = commit ? shd_val_q  : act_val_q;
    act_dp_d   = commit ? shd_dp_q   : act_dp_q;
    act_mask_d = commit ? shd_mask_q : act_mask_q;
    shd_val_d  = load ? value      : shd_val_q;
    shd_dp_d   = load ? dp_in      : shd_dp_q;
    shd_mask_d = load ? blank_mask : shd_mask_q;
    pending_d  = load | (pending_q & ~commit);

    suppress = '0;
    lz_run   = 1'b1;
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run & (act_val_d[4*i +: 4] == 4'h0) & ~act_dp_d[i];
      suppress[i] = lz_run;
    end
`endif
    dark = act_mask_d | suppress;

    an_d         = '1;
    digit_d      = 4'h0;
    dp_n_d       = 1'b1;
    frame_done_d = frame_end;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        digit_d = act_val_d[4*i +: 4];
        dp_n_d  = ~(drive_d & act_dp_d[i]);
        an_d[i] = ~(drive_d & ~dark[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shd_val_q    <= '0;
      shd_dp_q     <= '0;
      shd_mask_q   <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_mask_q   <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      digit_q      <= 4'h0;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shd_val_q    <= shd_val_d;
      shd_dp_q     <= shd_dp_d;
      shd_mask_q   <= shd_mask_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_mask_q   <= act_mask_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      digit_q      <= digit_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign digit      = digit_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// =============================================================================
// tb_seg_scan_ctrl : scoreboard bench for seg_scan_ctrl (DIGITS=4, REFRESH_DIV=8,
//                    BLANK_CYCLES=2). Revision 1.0
// =============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int F = D * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        dp_n;
  logic        frame_done;
  logic        pending;

  seg_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .an(an), .digit(digit), .dp_n(dp_n),
    .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [3:0] digit;
    logic       dp_n;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t expq[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: position t counts edges since reset release.
  int          m_t = 0;
  logic [15:0] m_sv = '0, m_av = '0;
  logic [3:0]  m_sd = '0, m_sm = '0, m_ad = '0, m_am = '0;
  bit          m_pend = 1'b0;

  function automatic bit m_lit(int i);
    bit allz;
    if (m_am[i]) return 1'b0;
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
    if (i > 0) begin
      allz = 1'b1;
      for (int k = i; k < D; k++) begin
        logic [15:0] v;
        v = m_av >> (4 * k);
        if (v[3:0] != 4'h0 || m_ad[k]) allz = 1'b0;
      end
      if (allz) return 1'b0;
    end
`else
    allz = 1'b0;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      exp_t        e;
      int          c, ix;
      logic [15:0] sh;
      if (((m_t + 1) % F == 0) && m_pend) begin
        m_av = m_sv; m_ad = m_sd; m_am = m_sm; m_pend = 1'b0;
      end
      if (load) begin
        m_sv = value; m_sd = dp_in; m_sm = blank_mask; m_pend = 1'b1;
      end
      m_t = m_t + 1;
      c  = m_t % R;
      ix = (m_t / R) % D;
      sh = m_av >> (4 * ix);
      e.t     = m_t;
      e.digit = sh[3:0];
      e.fd    = (m_t % F == 0);
      e.pend  = m_pend;
      if (c < B) begin
        e.an = 4'b1111; e.dp_n = 1'b1;
      end else begin
        e.an = m_lit(ix) ? ~(4'b0001 << ix) : 4'b1111;
        e.dp_n = ~m_ad[ix];
      end
      expq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_n && expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      n_total++;
      if ({an, digit, dp_n, frame_done, pending} === {e.an, e.digit, e.dp_n, e.fd, e.pend})
        n_pass++;
      else
        $display("FAIL outputs t=%0d: got an=%b digit=%h dp_n=%b fd=%b pend=%b, expected an=%b digit=%h dp_n=%b fd=%b pend=%b",
                 e.t, an, digit, dp_n, frame_done, pending, e.an, e.digit, e.dp_n, e.fd, e.pend);
      n_total++;
      if ($countones(~an) <= 1) n_pass++;
      else $display("FAIL an_onehot t=%0d: got an=%b, expected at most one low bit", e.t, an);
    end
  end

  task automatic check(string name, int act, int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d, logic [3:0] m);
    value = v; dp_in = d; blank_mask = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_pos(int pos);
    int k;
    for (k = 0; k <= F + 1; k++) begin
      if (m_t % F == pos) break;
      @(negedge clk);
    end
    if (k > F + 1) begin
      n_total++;
      $display("FAIL wait_pos: got timeout expected position %0d", pos);
    end
  endtask

  task automatic first_drive_check();
    int k;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (an != 4'b1111) break;
    end
    check("first_drive_cycles", k, B);
    check("first_drive_an", int'(an), int'(4'b1110));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    expq.delete();
    m_t = 0; m_sv = '0; m_av = '0; m_sd = '0; m_sm = '0; m_ad = '0; m_am = '0; m_pend = 1'b0;
    #1;
    check("rst_an", int'(an), int'(4'b1111));
    check("rst_digit", int'(digit), 0);
    check("rst_dp_n", int'(dp_n), 1);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_pending", int'(pending), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("por_an", int'(an), int'(4'b1111));
    check("por_pending", int'(pending), 0);
    rst_n = 1'b1;
    first_drive_check();

    do_load(16'hA3F1, 4'b0000, 4'b0000);
    run(3 * F);

    wait_pos(5);
    do_load(16'h1111, 4'b0000, 4'b0000);
    wait_pos(F - 1);
    do_load(16'h2222, 4'b0000, 4'b0000);
    check("pend_after_commit_load", int'(pending), 1);
    run(2 * F);

    do_load(16'hABCD, 4'b0001, 4'b0100);
    run(2 * F);
    do_load(16'h0070, 4'b0000, 4'b0000);
    run(2 * F);
    do_load(16'h0000, 4'b0000, 4'b0000);
    run(2 * F);
    do_load(16'h0070, 4'b0100, 4'b0000);
    run(2 * F);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
      do_load(v, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
      if ($urandom_range(0, 3) == 0) do_load(16'($urandom), 4'($urandom), 4'b0000);
      run($urandom_range(0, 40));
    end

    run(F);
    wait_pos(2 * R + 4);
    do_reset();
    first_drive_check();
    do_load(16'h5A0C, 4'b0010, 4'b0000);
    run(2 * F + 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

- Time-multiplexed scan controller for the board's common-anode seven-segment display.
- Holds a double-buffered hex value and rotates through the digits at a fixed refresh rate. For each digit it presents one nibble to the downstream hex-to-segment decoder and drives the matching active-low anode.
- Inserts a blanking gap between digits to suppress ghosting.
- Commits newly loaded values only at frame boundaries, so the display never tears.

## Interface

- `DIGITS`, 4: number of multiplexed digits (1..8).
- `REFRESH_DIV`, 100000: clock cycles per digit slot (≥ 2).
- `BLANK_CYCLES`, 1000: leading cycles of each slot with all anodes off (1 ≤ BLANK_CYCLES < REFRESH_DIV).
- `clk` in 1: system clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `load` in 1: single-cycle strobe that captures `value`, `dp_in` and `blank_mask` into the shadow buffer.
- `value` in 4*DIGITS: hex nibbles. Nibble i (bits 4i+3:4i) is digit i; digit 0 is the rightmost.
- `dp_in` in DIGITS: decimal-point enable per digit, active-high.
- `blank_mask` in DIGITS: 1 forces that digit dark.
- `an` out DIGITS: anode enables, active-low.
- `digit` out 4: nibble for the current slot; feeds the hex-to-segment decoder.
- `dp_n` out 1: decimal point, active-low.
- `frame_done` out 1: one-cycle pulse at each frame boundary.
- `pending` out 1: shadow buffer holds an uncommitted load.

## Operation

- Counter `cnt` runs 0..REFRESH_DIV-1. Digit index `idx` runs 0..DIGITS-1. `idx` advances when `cnt` = REFRESH_DIV-1 and wraps from DIGITS-1 to 0.
- Per-slot FSM:
  - BLANK while `cnt` < BLANK_CYCLES: `an` all ones, `dp_n` = 1.
  - DRIVE for the rest of the slot: `an[idx]` = 0 unless the digit is blanked; `dp_n` = ~dp[idx].
  - BLANK→DRIVE occurs at `cnt` = BLANK_CYCLES. DRIVE→BLANK occurs on slot wrap.
- `digit` = active nibble `idx` in both states. It is valid one slot-start ahead of the anode.
- Two buffers:
  - Shadow (value, dp, mask): written on `load`; sets `pending`.
  - Active buffer: copied from shadow at the frame boundary if `pending` = 1, which then clears `pending`. The frame boundary is the wrap from `idx` = DIGITS-1 to 0.
- `load` coincident with the commit edge: the commit takes the pre-load shadow. The new load is written to shadow and `pending` stays 1, so it commits at the next frame.
- Back-to-back loads: the last one wins.
- `load` while `pending` = 1 overwrites the shadow. No handshake stall; `load` is always accepted.
- Reset, at any time including mid-slot, forces:
  - `cnt` = 0, `idx` = 0, state BLANK
  - `an` = all ones, `digit` = 0, `dp_n` = 1
  - `frame_done` = 0, `pending` = 0
  - shadow and active buffers = 0, mask = 0

## Timing

- `an`, `digit`, `dp_n` and `frame_done` are registered. They change on the same edge that updates `cnt` and `idx`, and are consistent with them.
- `frame_done` is high for exactly the one cycle in which `cnt` = 0 and `idx` = 0 after a wrap. It is not asserted out of reset.
- Load-to-visible latency:
  - `load` at edge t updates shadow and `pending` at edge t+1.
  - The value is shown from the first frame that starts after commit, between 1 and DIGITS*REFRESH_DIV cycles later.
- Frame period: DIGITS*REFRESH_DIV cycles. Duty per digit: (REFRESH_DIV-BLANK_CYCLES)/(DIGITS*REFRESH_DIV).
- At most one anode is low in any cycle. Zero anodes are low during BLANK.

## Configuration

- `SEG_LEADING_ZERO_SUPPRESS_EN`
  - Defined: in the active buffer, every zero nibble from digit DIGITS-1 downward that has only zero nibbles above it is treated as blanked.
  - Digit 0 is never suppressed.
  - A digit whose `dp` bit is set stops suppression at that digit.
- Undefined: all digits are shown unless `blank_mask` is set.

## Test plan

Bench parameters for all scenarios: DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.

- Reset mid-DRIVE of digit 2 → `an`=4'b1111, `digit`=0, `dp_n`=1 immediately (async). After release the first DRIVE is on digit 0, reached at `cnt`=2.
- Load `value`=16'hA3F1 before frame 1 → after the next `frame_done`, the slot sequence shows:
  - `digit` 1 with `an`=4'b1110
  - F with 4'b1101
  - 3 with 4'b1011
  - A with 4'b0111
  - Each slot has 2 blank cycles (`an`=4'b1111) then 6 drive cycles. `frame_done` repeats every 32 cycles.
- Load 16'h1111, then 16'h2222 on the exact commit edge → the next frame shows 1111, `pending` stays 1, and the following frame shows 2222.
- `blank_mask`=4'b0100 and `dp_in`=4'b0001 → digit 2 anode never goes low; `dp_n`=0 only during DRIVE of digit 0.
- With `SEG_LEADING_ZERO_SUPPRESS_EN`: `value`=16'h0070 → digits 3 and 2 dark, digits 1 ("7") and 0 ("0") lit. `value`=16'h0000 → only digit 0 lit.
- Throughout all scenarios: assert that at most one `an` bit is 0 and that `an`=4'b1111 whenever `cnt` < 2.
